// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-ready stalls.
// Optional overflow trap on add/sub/addi is enabled by defining MC_OVF_TRAP_EN.
module mc_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       OF,
   input  logic       MemReady,
   output logic [2:0] ALUCtrl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ExtOp,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       Exc
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;

   state_t     state, state_nxt;
   logic [2:0] f_alu;
   logic       f_ok;
   logic       ovf;

   always_comb begin
      f_ok  = 1'b1;
      f_alu = 3'b000;
      case (Funct)
         6'b100000: f_alu = 3'b010;
         6'b100010: f_alu = 3'b011;
         6'b100100: f_alu = 3'b000;
         6'b100101: f_alu = 3'b001;
         6'b100110: f_alu = 3'b111;
         6'b100111: f_alu = 3'b110;
         6'b101010: f_alu = 3'b100;
         default:   f_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW:               state_nxt = S_MEMADR;
               OP_R:                       state_nxt = S_EXEC;
               OP_BEQ:                     state_nxt = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI:   state_nxt = S_IEXEC;
               OP_J:                       state_nxt = S_JUMP;
               default:                    state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_nxt = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_nxt = MemReady ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nxt = f_ok ? S_ALUWB : S_FETCH;
         S_IEXEC:  state_nxt = S_IWB;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

`ifdef MC_OVF_TRAP_EN
   // Flag lives for exactly one cycle: set from EXEC/IEXEC, consumed in ALUWB/IWB, cleared otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf <= 1'b0;
      else     ovf <= OF && (((state == S_EXEC) && ((Funct == F_ADD) || (Funct == F_SUB)))
                          || ((state == S_IEXEC) && (Op == OP_ADDI)));
   end
`else
   // OF is referenced only to keep the port read; the trap never fires.
   assign ovf = OF & 1'b0;
`endif

   always_comb begin
      ALUCtrl  = 3'b000;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ExtOp    = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      Exc      = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            ALUCtrl = 3'b010;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            ALUCtrl = 3'b010;
            ExtOp   = 1'b1;
            case (Op)
               OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: Exc = 1'b0;
               default: Exc = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
            ALUCtrl = 3'b010;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUCtrl = f_alu;
            Exc     = ~f_ok;
         end
         S_ALUWB: begin
            RegWrite = ~ovf;
            RegDst   = 1'b1;
            Exc      = ovf;
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (Op)
               OP_ANDI: ALUCtrl = 3'b000;
               OP_ORI:  ALUCtrl = 3'b001;
               default: begin
                  ALUCtrl = 3'b010;
                  ExtOp   = 1'b1;
               end
            endcase
         end
         S_IWB: begin
            RegWrite = ~ovf;
            Exc      = ovf;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUCtrl = 3'b011;
            PCSrc   = 2'b01;
            PCWrite = Zero;
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
         end
         default: ;
      endcase
      if (rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         Exc      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-by-cycle directed vector table for mc_ctrl; expectation follows MC_OVF_TRAP_EN.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, OF, MemReady;
  logic [2:0] ALUCtrl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSrc;
  logic       RegWrite, RegDst, MemtoReg, Exc;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .OF(OF), .MemReady(MemReady),
    .ALUCtrl(ALUCtrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Exc(Exc)
  );

  always #5 clk = ~clk;

  logic [17:0] got;
  assign got = {ALUCtrl, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite,
                IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg, Exc};

  typedef struct {
    string       nm;
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        of;
    logic        mr;
    logic [17:0] e;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  logic trap_en;
  logic done  = 1'b0;

  function automatic logic [17:0] ov(input logic [2:0] alu, input logic sa, input logic [1:0] sb,
                                     input logic ext, input logic iord, input logic mrd,
                                     input logic mwr, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic rw, input logic rd,
                                     input logic m2r, input logic exc);
    return {alu, sa, sb, ext, iord, mrd, mwr, irw, pcw, pcs, rw, rd, m2r, exc};
  endfunction

  logic [17:0] RST, F0, F1, DEC, DEC_X, MADR, MRD, MWB, MWR, ALUWB, ALUWB_T, IWB, IWB_T, JMP;

  task automatic add(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic of, input logic mr, input logic [17:0] e);
    vec_t v;
    v.nm = nm; v.r = r; v.op = op; v.fn = fn; v.z = z; v.of = of; v.mr = mr; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] alu, input logic of, input logic trap);
    add("r_fetch", 0, 6'b000000, fn, 0, 0, 1, F1);
    add("r_dec",   0, 6'b000000, fn, 0, 0, 0, DEC);
    add("r_exec",  0, 6'b000000, fn, 0, of, 0, ov(alu,1,2'b00,0,0,0,0,0,0,2'b00,0,0,0,0));
    add("r_wb",    0, 6'b000000, fn, 0, 0, 0, (trap && trap_en) ? ALUWB_T : ALUWB);
  endtask

  task automatic itype(input logic [5:0] op, input logic [2:0] alu, input logic ext,
                       input logic of, input logic trap);
    add("i_fetch", 0, op, 6'b0, 0, 0, 1, F1);
    add("i_dec",   0, op, 6'b0, 0, 0, 0, DEC);
    add("i_exec",  0, op, 6'b0, 0, of, 0, ov(alu,1,2'b10,ext,0,0,0,0,0,2'b00,0,0,0,0));
    add("i_wb",    0, op, 6'b0, 0, 0, 0, (trap && trap_en) ? IWB_T : IWB);
  endtask

  initial begin
    #100000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: vector run did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; OF = 1'b0; MemReady = 1'b0;
`ifdef MC_OVF_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    RST     = ov(3'b010,0,2'b01,0,0,0,0,0,0,2'b00,0,0,0,0);
    F0      = ov(3'b010,0,2'b01,0,0,1,0,0,0,2'b00,0,0,0,0);
    F1      = ov(3'b010,0,2'b01,0,0,1,0,1,1,2'b00,0,0,0,0);
    DEC     = ov(3'b010,0,2'b11,1,0,0,0,0,0,2'b00,0,0,0,0);
    DEC_X   = ov(3'b010,0,2'b11,1,0,0,0,0,0,2'b00,0,0,0,1);
    MADR    = ov(3'b010,1,2'b10,1,0,0,0,0,0,2'b00,0,0,0,0);
    MRD     = ov(3'b000,0,2'b00,0,1,1,0,0,0,2'b00,0,0,0,0);
    MWB     = ov(3'b000,0,2'b00,0,0,0,0,0,0,2'b00,1,0,1,0);
    MWR     = ov(3'b000,0,2'b00,0,1,0,1,0,0,2'b00,0,0,0,0);
    ALUWB   = ov(3'b000,0,2'b00,0,0,0,0,0,0,2'b00,1,1,0,0);
    ALUWB_T = ov(3'b000,0,2'b00,0,0,0,0,0,0,2'b00,0,1,0,1);
    IWB     = ov(3'b000,0,2'b00,0,0,0,0,0,0,2'b00,1,0,0,0);
    IWB_T   = ov(3'b000,0,2'b00,0,0,0,0,0,0,2'b00,0,0,0,1);
    JMP     = ov(3'b000,0,2'b00,0,0,0,0,0,1,2'b10,0,0,0,0);

    #1;
    total++;
    if (got !== RST) begin
      bad++;
      $display("FAIL reset state: got %b want %b", got, RST);
    end

    add("reset",       1, 6'b0, 6'b0, 0, 0, 1, RST);
    add("post_reset",  0, 6'b0, 6'b0, 0, 0, 0, F0);
    add("lw_fetch",  0, 6'b100011, 6'b0, 0, 0, 1, F1);
    add("lw_dec",    0, 6'b100011, 6'b0, 0, 0, 0, DEC);
    add("lw_madr",   0, 6'b100011, 6'b0, 0, 0, 0, MADR);
    add("lw_mrd",    0, 6'b100011, 6'b0, 0, 0, 1, MRD);
    add("lw_mwb",    0, 6'b100011, 6'b0, 0, 0, 0, MWB);
    add("lws_fetch", 0, 6'b100011, 6'b0, 0, 0, 1, F1);
    add("lws_dec",   0, 6'b100011, 6'b0, 0, 0, 0, DEC);
    add("lws_madr",  0, 6'b100011, 6'b0, 0, 0, 0, MADR);
    for (int unsigned i = 0; i < 3; i++) add("lws_stall", 0, 6'b100011, 6'b0, 0, 0, 0, MRD);
    add("lws_mrd",   0, 6'b100011, 6'b0, 0, 0, 1, MRD);
    add("lws_mwb",   0, 6'b100011, 6'b0, 0, 0, 0, MWB);
    add("sw_fstall", 0, 6'b101011, 6'b0, 0, 0, 0, F0);
    add("sw_fetch",  0, 6'b101011, 6'b0, 0, 0, 1, F1);
    add("sw_dec",    0, 6'b101011, 6'b0, 0, 0, 0, DEC);
    add("sw_madr",   0, 6'b101011, 6'b0, 0, 0, 0, MADR);
    add("sw_wstall", 0, 6'b101011, 6'b0, 0, 0, 0, MWR);
    add("sw_mwr",    0, 6'b101011, 6'b0, 0, 0, 1, MWR);
    rtype(6'b100000, 3'b010, 0, 0);
    rtype(6'b100010, 3'b011, 0, 0);
    rtype(6'b100100, 3'b000, 0, 0);
    rtype(6'b100101, 3'b001, 0, 0);
    rtype(6'b100110, 3'b111, 0, 0);
    rtype(6'b100111, 3'b110, 0, 0);
    rtype(6'b101010, 3'b100, 0, 0);
    add("rx_fetch",  0, 6'b000000, 6'b000001, 0, 0, 1, F1);
    add("rx_dec",    0, 6'b000000, 6'b000001, 0, 0, 0, DEC);
    add("rx_exec",   0, 6'b000000, 6'b000001, 0, 0, 0, ov(3'b000,1,2'b00,0,0,0,0,0,0,2'b00,0,0,0,1));
    add("beq1_fetch", 0, 6'b000100, 6'b0, 0, 0, 1, F1);
    add("beq1_dec",   0, 6'b000100, 6'b0, 0, 0, 0, DEC);
    add("beq1_br",    0, 6'b000100, 6'b0, 1, 0, 0, ov(3'b011,1,2'b00,0,0,0,0,0,1,2'b01,0,0,0,0));
    add("beq0_fetch", 0, 6'b000100, 6'b0, 1, 0, 1, F1);
    add("beq0_dec",   0, 6'b000100, 6'b0, 1, 0, 0, DEC);
    add("beq0_br",    0, 6'b000100, 6'b0, 0, 0, 0, ov(3'b011,1,2'b00,0,0,0,0,0,0,2'b01,0,0,0,0));
    itype(6'b001000, 3'b010, 1, 0, 0);
    itype(6'b001100, 3'b000, 0, 0, 0);
    itype(6'b001101, 3'b001, 0, 0, 0);
    add("j_fetch",   0, 6'b000010, 6'b0, 0, 0, 1, F1);
    add("j_dec",     0, 6'b000010, 6'b0, 0, 0, 0, DEC);
    add("j_jump",    0, 6'b000010, 6'b0, 0, 0, 0, JMP);
    add("ill_fetch", 0, 6'b111111, 6'b0, 0, 0, 1, F1);
    add("ill_dec",   0, 6'b111111, 6'b0, 0, 0, 0, DEC_X);
    rtype(6'b100000, 3'b010, 1, 1);
    rtype(6'b100100, 3'b000, 1, 0);
    rtype(6'b100010, 3'b011, 1, 1);
    itype(6'b001000, 3'b010, 1, 1, 1);
    itype(6'b001100, 3'b000, 0, 1, 0);
    rtype(6'b100000, 3'b010, 0, 0);
    add("rr_fetch",  0, 6'b100011, 6'b0, 0, 0, 1, F1);
    add("rr_dec",    0, 6'b100011, 6'b0, 0, 0, 0, DEC);
    add("rr_madr",   0, 6'b100011, 6'b0, 0, 0, 0, MADR);
    add("rr_mrd",    0, 6'b100011, 6'b0, 0, 0, 0, MRD);
    add("rr_reset",  1, 6'b100011, 6'b0, 0, 0, 1, RST);
    add("rr_fetch2", 0, 6'b100011, 6'b0, 0, 0, 1, F1);
    add("rr_dec2",   0, 6'b100011, 6'b0, 0, 0, 0, DEC);
    add("rr_madr2",  0, 6'b100011, 6'b0, 0, 0, 0, MADR);
    add("rr_mrd2",   0, 6'b100011, 6'b0, 0, 0, 1, MRD);
    add("rr_mwb2",   0, 6'b100011, 6'b0, 0, 0, 0, MWB);
    add("final",     0, 6'b000000, 6'b0, 0, 0, 0, F0);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; Op = tbl[i].op; Funct = tbl[i].fn;
      Zero = tbl[i].z; OF = tbl[i].of; MemReady = tbl[i].mr;
      #1;
      total++;
      if (got !== tbl[i].e) begin
        bad++;
        $display("FAIL row %0d %s: got %b want %b", i, tbl[i].nm, got, tbl[i].e);
      end
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the 3-bit `ALUCtrl` code and the datapath mux selects and write strobes. It consumes the ALU's `Zero` and `OF` flags to resolve branches and arithmetic overflow. It also stalls on a memory ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Op`  in  6  instruction opcode, from the instruction register
- `Funct`  in  6  R-type function field, from the instruction register
- `Zero`  in  1  ALU zero flag
- `OF`  in  1  ALU overflow flag
- `MemReady`  in  1  memory completed the current access this cycle
- `ALUCtrl`  out  3  ALU operation select
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 110 NOR, 111 XOR
- `ALUSrcA`  out  1  ALU input A select: 0 = PC, 1 = register A
- `ALUSrcB`  out  2  ALU input B select: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate shifted left 2
- `ExtOp`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  load the instruction register
- `PCWrite`  out  1  load the PC
- `PCSrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `RegWrite`  out  1  register file write enable
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd
- `MemtoReg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `Exc`  out  1  one-cycle pulse on an illegal opcode or a trapped overflow

## Operation
- State register: 4 bits. Outputs are decoded combinationally from the state register and the inputs.
- In every state, any output not listed for that state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=010.
  - IRWrite = PCWrite = MemReady. PCSrc=00.
  - Stays in FETCH while MemReady=0. Goes to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUCtrl=010, ExtOp=1 (precomputes the branch target).
  - Next state by Op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi), 001100 (andi), 001101 (ori) → IEXEC
    - 000010 (j) → JUMP
    - any other Op: Exc=1, → FETCH
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUCtrl=010.
  - → MEMRD for lw, → MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Stays until MemReady=1, then → MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. → FETCH.
- MEMWR: MemWrite=1, IorD=1. Stays until MemReady=1, then → FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00.
  - ALUCtrl by Funct: 100000 → 010, 100010 → 011, 100100 → 000, 100101 → 001, 100110 → 111, 100111 → 110, 101010 → 100.
  - Any other Funct: Exc=1, → FETCH. Otherwise → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. → FETCH.
- IEXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - addi: ALUCtrl=010, ExtOp=1. andi: ALUCtrl=000, ExtOp=0. ori: ALUCtrl=001, ExtOp=0.
  - → IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. → FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUCtrl=011, PCSrc=01, PCWrite=Zero.
  - → FETCH.
- JUMP: PCWrite=1, PCSrc=10. → FETCH.

## Timing
- Reset:
  - Asynchronous; state becomes FETCH immediately.
  - While `rst`=1, all strobes are forced to 0: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Exc. Mux selects show FETCH values.
  - A reset asserted mid-instruction abandons the instruction; no writeback occurs.
- Latency with MemReady tied to 1:
  - lw 5 cycles; sw, R-type and I-type 4 cycles; beq and j 3 cycles; illegal opcode 2 cycles.
  - Each cycle MemReady is held low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemReady is sampled only in FETCH, MEMRD and MEMWR; it is ignored in all other states.
- Zero is sampled combinationally in BRANCH only.

## Configuration
- `MC_OVF_TRAP_EN` defined:
  - In EXEC for add/sub, and in IEXEC for addi, OF is registered into an internal flag on the clock edge.
  - If the flag is set, the following ALUWB/IWB cycle has RegWrite=0 and Exc=1.
  - The flag clears on reset and on every entry to FETCH.
- `MC_OVF_TRAP_EN` undefined: OF is ignored and overflowing results are written normally.

## Test plan
- Reset mid-MEMRD, then release with MemReady=1: state is FETCH; no RegWrite pulse; next instruction completes normally.
- lw (Op=100011) with MemReady=1 every cycle: 5 cycles; RegWrite=1 with MemtoReg=1 in cycle 5. Hold MemReady=0 for 3 cycles in MEMRD: 8 cycles total.
- R-type sweep, Funct 100000/100010/100100/100101/100110/100111/101010: EXEC shows ALUCtrl 010/011/000/001/111/110/100 respectively. Funct=000001: Exc pulse, return to FETCH.
- beq with Zero=1: PCWrite=1 and PCSrc=01 in cycle 3. With Zero=0: PCWrite=0 in cycle 3.
- add with OF=1 in EXEC:
  - macro defined: RegWrite=0 and Exc=1 in ALUWB.
  - macro undefined: RegWrite=1 and Exc=0.
- Op=111111: Exc=1 in DECODE; FETCH on the next cycle; no other strobes asserted.
